// File: rtl/conv3x3_stream_if.sv
// Pixel/coefficient stream bundle for conv3x3_stream. The master drives pixels
// and coefficient writes; the slave (the engine) returns filtered pixels.
interface conv3x3_stream_if #(
    parameter int PIX_W  = 4,
    parameter int COEF_W = 5
);
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_in;
    logic              sof;
    logic              coef_we;
    logic [3:0]        coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              out_valid;
    logic [PIX_W-1:0]  pix_out;
    logic              out_border;
    logic              out_eof;

    modport master (
        output pix_valid, pix_in, sof, coef_we, coef_addr, coef_data,
        input  out_valid, pix_out, out_border, out_eof
    );

    modport slave (
        input  pix_valid, pix_in, sof, coef_we, coef_addr, coef_data,
        output out_valid, pix_out, out_border, out_eof
    );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution with internal line buffers, border masking and a
// 3-stage product/sum/saturate pipeline. Define ABS_MAG_EN for |sum| output.
module conv3x3_stream #(
    parameter int PIX_W  = 4,
    parameter int COEF_W = 5,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int SHIFT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    conv3x3_stream_if.slave  bus
);
    localparam int PROD_W = COEF_W + PIX_W + 1;
    localparam int SUM_W  = COEF_W + PIX_W + 5;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam logic [COL_W-1:0]        LAST_COL  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]        LAST_ROW  = ROW_W'(IMG_H - 1);
    localparam logic signed [SUM_W-1:0] PIX_MAX_S = SUM_W'((1 << PIX_W) - 1);

    // Signed coefficient times zero-extended unsigned pixel.
    function automatic logic signed [PROD_W-1:0] mul_f(
        input logic signed [COEF_W-1:0] c,
        input logic        [PIX_W-1:0]  p
    );
        logic signed [PROD_W-1:0] a;
        logic signed [PROD_W-1:0] b;
        a = {{(PROD_W-COEF_W){c[COEF_W-1]}}, c};
        b = {{(COEF_W+1){1'b0}}, p};
        return a * b;
    endfunction

    logic [COL_W-1:0] col_q, col_d, cur_col_s;
    logic [ROW_W-1:0] row_q, row_d, cur_row_s;
    logic             border_s, eof_s;

    logic [PIX_W-1:0] lb1_q [IMG_W];
    logic [PIX_W-1:0] lb2_q [IMG_W];
    logic [PIX_W-1:0] lb1_rd_s, lb2_rd_s;
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] win_d [3][3];

    logic signed [COEF_W-1:0] coef_q [9];
    logic signed [PROD_W-1:0] prod_s [9];
    logic signed [PROD_W-1:0] prod_q [9];
    logic                     v1_q, bd1_q, eof1_q;
    logic signed [SUM_W-1:0]  sum_s, sum_q;
    logic                     v2_q, bd2_q, eof2_q;
    logic signed [SUM_W-1:0]  mag_s, shr_s;
    logic [PIX_W-1:0]         res_s;

    logic             out_valid_q, out_border_q, out_eof_q;
    logic [PIX_W-1:0] pix_out_q;

    // Position of the current pixel (sof restarts the frame) and the counter advance.
    always_comb begin
        cur_col_s = bus.sof ? '0 : col_q;
        cur_row_s = bus.sof ? '0 : row_q;
        col_d     = col_q;
        row_d     = row_q;
        if (bus.pix_valid) begin
            if (cur_col_s == LAST_COL) begin
                col_d = '0;
                if (cur_row_s == LAST_ROW) begin
                    row_d = '0;
                end else begin
                    row_d = cur_row_s + ROW_W'(1);
                end
            end else begin
                col_d = cur_col_s + COL_W'(1);
                row_d = cur_row_s;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
        border_s = (cur_row_s < ROW_W'(2)) || (cur_col_s < COL_W'(2));
        eof_s    = (cur_row_s == LAST_ROW) && (cur_col_s == LAST_COL);
    end

    // Row/column counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign lb1_rd_s = lb1_q[cur_col_s];
    assign lb2_rd_s = lb2_q[cur_col_s];

    // Line buffers are read-before-write; contents are never cleared.
    always_ff @(posedge clk) begin
        if (bus.pix_valid) begin
            lb1_q[cur_col_s] <= bus.pix_in;
            lb2_q[cur_col_s] <= lb1_rd_s;
        end else begin
            lb1_q[cur_col_s] <= lb1_q[cur_col_s];
            lb2_q[cur_col_s] <= lb2_q[cur_col_s];
        end
    end

    // Window after this pixel: columns shift left, new column enters on the right.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            win_d[k][0] = win_q[k][1];
            win_d[k][1] = win_q[k][2];
        end
        win_d[0][2] = lb2_rd_s;
        win_d[1][2] = lb1_rd_s;
        win_d[2][2] = bus.pix_in;
    end

    // Window register.
    always_ff @(posedge clk) begin
        if (bus.pix_valid) begin
            win_q <= win_d;
        end else begin
            win_q <= win_q;
        end
    end

    // Coefficient store; reset loads the Laplacian, out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                coef_q[k] <= (k == 4) ? COEF_W'(8) : {COEF_W{1'b1}};
            end
        end else if (bus.coef_we && (bus.coef_addr <= 4'd8)) begin
            coef_q[bus.coef_addr] <= bus.coef_data;
        end else begin
            coef_q <= coef_q;
        end
    end

    // S1 products use the pre-write coefficients of this cycle.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            prod_s[k] = mul_f(coef_q[k], win_d[k / 3][k % 3]);
        end
    end

    // Adder tree over the registered products; SUM_W leaves headroom for nine terms.
    always_comb begin
        sum_s = '0;
        for (int k = 0; k < 9; k++) begin
            sum_s = sum_s + {{(SUM_W-PROD_W){prod_q[k][PROD_W-1]}}, prod_q[k]};
        end
    end

    // S3 normalise and saturate; border positions are forced to zero.
    always_comb begin
`ifdef ABS_MAG_EN
        mag_s = sum_q[SUM_W-1] ? -sum_q : sum_q;
`else
        mag_s = sum_q;
`endif
        shr_s = mag_s >>> SHIFT;
        if (bd2_q) begin
            res_s = '0;
        end else if (shr_s[SUM_W-1]) begin
            res_s = '0;
        end else if (shr_s > PIX_MAX_S) begin
            res_s = {PIX_W{1'b1}};
        end else begin
            res_s = shr_s[PIX_W-1:0];
        end
    end

    // Pipeline stages S1..S3; only the valid bits and outputs need reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            out_valid_q  <= 1'b0;
            pix_out_q    <= '0;
            out_border_q <= 1'b0;
            out_eof_q    <= 1'b0;
        end else begin
            v1_q         <= bus.pix_valid;
            v2_q         <= v1_q;
            out_valid_q  <= v2_q;
            pix_out_q    <= v2_q ? res_s : pix_out_q;
            out_border_q <= v2_q & bd2_q;
            out_eof_q    <= v2_q & eof2_q;
        end
        prod_q <= prod_s;
        bd1_q  <= border_s;
        eof1_q <= eof_s;
        sum_q  <= sum_s;
        bd2_q  <= bd1_q;
        eof2_q <= eof1_q;
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.pix_out    = pix_out_q;
    assign bus.out_border = out_border_q;
    assign bus.out_eof    = out_eof_q;
endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on an 8x6 image; outputs are collected on
// the falling edge and compared against hand-derived expectations per scenario.
module tb_conv3x3_stream;
    localparam int PIX_W = 4, COEF_W = 5, IMG_W = 8, IMG_H = 6, SHIFT = 0;
    localparam int NPIX = IMG_W * IMG_H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv3x3_stream_if #(.PIX_W(PIX_W), .COEF_W(COEF_W)) bus ();

    conv3x3_stream #(
        .PIX_W(PIX_W), .COEF_W(COEF_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .SHIFT(SHIFT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int oq_pix[$], oq_bd[$], oq_eof[$], oq_cyc[$], iq_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            oq_pix.push_back(int'(bus.pix_out));
            oq_bd.push_back(int'(bus.out_border));
            oq_eof.push_back(int'(bus.out_eof));
            oq_cyc.push_back(cyc);
        end
    end

    function automatic int exp_bd(int i);
        return ((i / IMG_W) < 2 || (i % IMG_W) < 2) ? 1 : 0;
    endfunction

    // Identity kernel on the ramp: output is the pixel one row and one column back.
    function automatic int exp_ramp(int i);
        int r, c;
        r = i / IMG_W;
        c = i % IMG_W;
        if (r < 2 || c < 2) return 0;
        return ((r - 1) * 8 + (c - 1)) & 15;
    endfunction

    task automatic clear_q();
        oq_pix.delete(); oq_bd.delete(); oq_eof.delete(); oq_cyc.delete(); iq_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bus.pix_valid = 1'b0; bus.sof = 1'b0; bus.coef_we = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic put_pix(input logic [3:0] p, input logic s);
        bus.pix_valid = 1'b1; bus.pix_in = p; bus.sof = s;
        iq_cyc.push_back(cyc);
        @(posedge clk); #1;
        bus.pix_valid = 1'b0; bus.sof = 1'b0;
    endtask

    task automatic put_coef(input logic [3:0] a, input logic [4:0] d);
        bus.coef_we = 1'b1; bus.coef_addr = a; bus.coef_data = d;
        @(posedge clk); #1;
        bus.coef_we = 1'b0;
    endtask

    task automatic load_identity();
        for (int a = 0; a < 9; a++) put_coef(4'(a), (a == 4) ? 5'd1 : 5'd0);
        put_coef(4'd12, 5'd7);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.pix_out !== 4'd0 || bus.out_border !== 1'b0 || bus.out_eof !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b pix=%0d bd=%b eof=%b, expected all 0",
                     bus.out_valid, bus.pix_out, bus.out_border, bus.out_eof);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_laplace_const();
        clear_q();
        for (int i = 0; i < NPIX; i++) put_pix(4'd5, i == 0);
        idle(6);
        tests++;
        if (oq_pix.size() !== NPIX) begin
            fails++; $display("FAIL lap_count: got %0d, expected %0d", oq_pix.size(), NPIX);
        end
        for (int i = 0; i < oq_pix.size() && i < NPIX; i++) begin
            tests++;
            if (oq_pix[i] !== 0 || oq_bd[i] !== exp_bd(i) || oq_eof[i] !== int'(i == NPIX - 1)
                || oq_cyc[i] - iq_cyc[i] !== 3) begin
                fails++;
                $display("FAIL lap_const[%0d]: got pix=%0d bd=%0d eof=%0d lat=%0d, expected pix=0 bd=%0d eof=%0d lat=3",
                         i, oq_pix[i], oq_bd[i], oq_eof[i], oq_cyc[i] - iq_cyc[i], exp_bd(i), int'(i == NPIX - 1));
            end
        end
    endtask

    task automatic test_identity_ramp();
        load_identity();
        clear_q();
        for (int i = 0; i < NPIX; i++) put_pix(4'(i), i == 0);
        idle(6);
        tests++;
        if (oq_pix.size() !== NPIX) begin
            fails++; $display("FAIL ramp_count: got %0d, expected %0d", oq_pix.size(), NPIX);
        end
        for (int i = 0; i < oq_pix.size() && i < NPIX; i++) begin
            tests++;
            if (oq_pix[i] !== exp_ramp(i) || oq_bd[i] !== exp_bd(i) || oq_eof[i] !== int'(i == NPIX - 1)
                || oq_cyc[i] - iq_cyc[i] !== 3) begin
                fails++;
                $display("FAIL ramp[%0d]: got pix=%0d bd=%0d eof=%0d lat=%0d, expected pix=%0d bd=%0d lat=3",
                         i, oq_pix[i], oq_bd[i], oq_eof[i], oq_cyc[i] - iq_cyc[i], exp_ramp(i), exp_bd(i));
            end
        end
    endtask

    task automatic test_impulse();
        int r, c, e, nb;
        rst = 1'b1; idle(2); rst = 1'b0;
        clear_q();
        for (int i = 0; i < NPIX; i++) put_pix((i == 3 * IMG_W + 3) ? 4'd15 : 4'd0, i == 0);
        idle(6);
        nb = 0;
`ifdef ABS_MAG_EN
        nb = 15;
`endif
        tests++;
        if (oq_pix.size() !== NPIX) begin
            fails++; $display("FAIL imp_count: got %0d, expected %0d", oq_pix.size(), NPIX);
        end
        for (int i = 0; i < oq_pix.size() && i < NPIX; i++) begin
            r = i / IMG_W - 1;
            c = i % IMG_W - 1;
            if (exp_bd(i) == 1) e = 0;
            else if (r == 3 && c == 3) e = 15;
            else if (r >= 2 && r <= 4 && c >= 2 && c <= 4) e = nb;
            else e = 0;
            tests++;
            if (oq_pix[i] !== e || oq_bd[i] !== exp_bd(i)) begin
                fails++;
                $display("FAIL impulse[%0d]: got pix=%0d bd=%0d, expected pix=%0d bd=%0d",
                         i, oq_pix[i], oq_bd[i], e, exp_bd(i));
            end
        end
    endtask

    task automatic test_gaps();
        load_identity();
        clear_q();
        for (int i = 0; i < NPIX; i++) begin
            if ($urandom_range(1, 0) == 1) idle(1);
            put_pix(4'(i), i == 0);
        end
        idle(6);
        tests++;
        if (oq_pix.size() !== iq_cyc.size()) begin
            fails++; $display("FAIL gap_count: got %0d outputs, expected %0d", oq_pix.size(), iq_cyc.size());
        end
        for (int i = 0; i < oq_pix.size() && i < NPIX; i++) begin
            tests++;
            if (oq_pix[i] !== exp_ramp(i) || oq_bd[i] !== exp_bd(i) || oq_eof[i] !== int'(i == NPIX - 1)
                || oq_cyc[i] - iq_cyc[i] !== 3) begin
                fails++;
                $display("FAIL gaps[%0d]: got pix=%0d bd=%0d eof=%0d lat=%0d, expected pix=%0d bd=%0d lat=3",
                         i, oq_pix[i], oq_bd[i], oq_eof[i], oq_cyc[i] - iq_cyc[i], exp_ramp(i), exp_bd(i));
            end
        end
    endtask

    task automatic test_sof_restart();
        int k;
        clear_q();
        for (int i = 0; i < 20; i++) put_pix(4'(i), i == 0);
        for (int i = 0; i < NPIX; i++) put_pix(4'(i), i == 0);
        idle(6);
        tests++;
        if (oq_pix.size() !== 20 + NPIX) begin
            fails++; $display("FAIL sof_count: got %0d, expected %0d", oq_pix.size(), 20 + NPIX);
        end
        for (int j = 0; j < oq_pix.size() && j < 20 + NPIX; j++) begin
            k = (j < 20) ? j : j - 20;
            tests++;
            if (oq_pix[j] !== exp_ramp(k) || oq_bd[j] !== exp_bd(k)
                || oq_eof[j] !== int'(j == 20 + NPIX - 1)) begin
                fails++;
                $display("FAIL sof[%0d]: got pix=%0d bd=%0d eof=%0d, expected pix=%0d bd=%0d eof=%0d",
                         j, oq_pix[j], oq_bd[j], oq_eof[j], exp_ramp(k), exp_bd(k), int'(j == 20 + NPIX - 1));
            end
        end
    endtask

    task automatic test_reset_midframe();
        clear_q();
        for (int i = 0; i <= 30; i++) put_pix(4'(i), i == 0);
        idle(1);
        rst = 1'b1;
        idle(2);
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL midrst_valid: got %b, expected 0", bus.out_valid);
        end
        rst = 1'b0;
        idle(4);
        tests++;
        if (oq_pix.size() !== 30) begin
            fails++; $display("FAIL midrst_count: got %0d, expected 30", oq_pix.size());
        end
        for (int i = 0; i < oq_pix.size() && i < 30; i++) begin
            tests++;
            if (oq_pix[i] !== exp_ramp(i) || oq_bd[i] !== exp_bd(i)) begin
                fails++;
                $display("FAIL midrst_pre[%0d]: got pix=%0d bd=%0d, expected pix=%0d bd=%0d",
                         i, oq_pix[i], oq_bd[i], exp_ramp(i), exp_bd(i));
            end
        end
        clear_q();
        for (int i = 0; i < NPIX; i++) put_pix(4'd5, 1'b0);
        idle(6);
        tests++;
        if (oq_pix.size() !== NPIX) begin
            fails++; $display("FAIL midrst_post_count: got %0d, expected %0d", oq_pix.size(), NPIX);
        end
        for (int i = 0; i < oq_pix.size() && i < NPIX; i++) begin
            tests++;
            if (oq_pix[i] !== 0 || oq_bd[i] !== exp_bd(i) || oq_eof[i] !== int'(i == NPIX - 1)) begin
                fails++;
                $display("FAIL midrst_post[%0d]: got pix=%0d bd=%0d eof=%0d, expected pix=0 bd=%0d eof=%0d",
                         i, oq_pix[i], oq_bd[i], oq_eof[i], exp_bd(i), int'(i == NPIX - 1));
            end
        end
    endtask

    initial begin
        bus.pix_valid = 1'b0; bus.pix_in = '0; bus.sof = 1'b0;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
        test_reset();
        test_laplace_const();
        test_identity_ramp();
        test_impulse();
        test_gaps();
        test_sof_restart();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
